// File: rtl/wbm_spi_ctrl.sv
// Purpose: turns SPI command bytes into single pipelined Wishbone B4 transactions and returns status/read-data bytes.
// Latency: last rx byte -> stb at the next edge; ack -> tx_valid one cycle later; abort after TIMEOUT cycles of cyc.
// Backpressure: rx bytes consumed only in CMD/ADDR/WDATA (one outstanding transaction); each tx byte held until tx_ack_i.
module wbm_spi_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        wbm_clk_i,
  input  logic        wbm_rst_ni,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic        rx_ack_o,
  output logic        tx_valid_o,
  output logic [7:0]  tx_data_o,
  input  logic        tx_ack_i,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [7:0]  wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_stall_i,
  input  logic        wbm_ack_i
);

  // The counter only has to reach TIMEOUT-1: the abort fires on that cycle.
  localparam int              TW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);

  localparam logic [7:0] ST_OK  = 8'h00;
  localparam logic [7:0] ST_BAD = 8'hC0;
  localparam logic [7:0] ST_TMO = 8'hEE;

  typedef enum logic [2:0] {
    S_CMD    = 3'd0,
    S_ADDR   = 3'd1,
    S_WDATA  = 3'd2,
    S_REQ    = 3'd3,
    S_WAIT   = 3'd4,
    S_STATUS = 3'd5,
    S_RDATA  = 3'd6
  } state_t;

  state_t         r_state;
  state_t         w_next;

  logic           r_we;
  logic [3:0]     r_sel;
  logic [7:0]     r_adr;
  logic [31:0]    r_dat;
  logic [31:0]    r_rdata;
  logic [7:0]     r_status;
  logic [1:0]     r_cnt;
  logic [TW-1:0]  r_tmo;

  logic           w_bad_cmd;
  logic           w_busy;
  logic           w_done;
  logic           w_abort;
  logic [31:0]    w_rshift;
  logic [7:0]     w_rbyte;

  // Reserved command bits must be zero for the frame to be accepted.
  assign w_bad_cmd = (rx_data_i[6:4] != 3'b000);

  // cyc is held in REQ and WAIT; the timeout window covers exactly these states.
  assign w_busy = (r_state == S_REQ) || (r_state == S_WAIT);

  // An ack in REQ only counts on the cycle the strobe is actually accepted.
  assign w_done = ((r_state == S_REQ) && !wbm_stall_i && wbm_ack_i) ||
                  ((r_state == S_WAIT) && wbm_ack_i);

  // Ack on the last allowed cycle still wins over the abort.
  assign w_abort = w_busy && !w_done && (r_tmo == TMO_LAST);

  // Read data goes out MSB first; r_cnt selects the byte.
  assign w_rshift = r_rdata << {r_cnt, 3'b000};
  assign w_rbyte  = w_rshift[31:24];

  assign wbm_we_o  = r_we;
  assign wbm_sel_o = r_sel;
  assign wbm_adr_o = r_adr;
  assign wbm_dat_o = r_dat;

  // State register.
  always_ff @(posedge wbm_clk_i) begin
    if (!wbm_rst_ni) begin
      r_state <= S_CMD;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_CMD: begin
        if (rx_valid_i) begin
          w_next = w_bad_cmd ? S_STATUS : S_ADDR;
        end
      end
      S_ADDR: begin
        if (rx_valid_i) begin
          w_next = r_we ? S_WDATA : S_REQ;
        end
      end
      S_WDATA: begin
        if (rx_valid_i && (r_cnt == 2'd3)) begin
          w_next = S_REQ;
        end
      end
      S_REQ: begin
        if (w_done || w_abort) begin
          w_next = S_STATUS;
        end else if (!wbm_stall_i) begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_done || w_abort) begin
          w_next = S_STATUS;
        end
      end
      S_STATUS: begin
        if (tx_ack_i) begin
          w_next = (r_we || (r_status == ST_BAD)) ? S_CMD : S_RDATA;
        end
      end
      S_RDATA: begin
        if (tx_ack_i && (r_cnt == 2'd3)) begin
          w_next = S_CMD;
        end
      end
      default: w_next = S_CMD;
    endcase
  end

  // Outputs decoded from the current state only.
  always_comb begin
    rx_ack_o   = 1'b0;
    wbm_cyc_o  = 1'b0;
    wbm_stb_o  = 1'b0;
    tx_valid_o = 1'b0;
    tx_data_o  = 8'h00;
    unique case (r_state)
      S_CMD, S_ADDR, S_WDATA: begin
        rx_ack_o = rx_valid_i;
      end
      S_REQ: begin
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
      end
      S_WAIT: begin
        wbm_cyc_o = 1'b1;
      end
      S_STATUS: begin
        tx_valid_o = 1'b1;
        tx_data_o  = r_status;
      end
      S_RDATA: begin
        tx_valid_o = 1'b1;
        tx_data_o  = w_rbyte;
      end
      default: begin
        rx_ack_o = 1'b0;
      end
    endcase
  end

  // Command and address fields captured as their bytes arrive.
  always_ff @(posedge wbm_clk_i) begin
    if (!wbm_rst_ni) begin
      r_we  <= 1'b0;
      r_sel <= 4'h0;
      r_adr <= 8'h00;
    end else begin
      if ((r_state == S_CMD) && rx_valid_i) begin
        r_we  <= rx_data_i[7];
        r_sel <= rx_data_i[3:0];
      end
      if ((r_state == S_ADDR) && rx_valid_i) begin
        r_adr <= rx_data_i;
      end
    end
  end

  // Write data shifts in from the LSB end so the first byte lands in [31:24].
  always_ff @(posedge wbm_clk_i) begin
    if (!wbm_rst_ni) begin
      r_dat <= 32'h0;
    end else if ((r_state == S_WDATA) && rx_valid_i) begin
      r_dat <= {r_dat[23:0], rx_data_i};
    end
  end

  // Byte counter shared by the write-data and read-data phases.
  always_ff @(posedge wbm_clk_i) begin
    if (!wbm_rst_ni) begin
      r_cnt <= 2'd0;
    end else begin
      unique case (r_state)
        S_ADDR: begin
          if (rx_valid_i) begin
            r_cnt <= 2'd0;
          end
        end
        S_WDATA: begin
          if (rx_valid_i) begin
            r_cnt <= r_cnt + 2'd1;
          end
        end
        S_STATUS: begin
          if (tx_ack_i) begin
            r_cnt <= 2'd0;
          end
        end
        S_RDATA: begin
          if (tx_ack_i) begin
            r_cnt <= r_cnt + 2'd1;
          end
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  // Timeout counter runs every cycle cyc is high and clears otherwise.
  always_ff @(posedge wbm_clk_i) begin
    if (!wbm_rst_ni) begin
      r_tmo <= '0;
    end else if (w_busy) begin
      r_tmo <= r_tmo + TW'(1);
    end else begin
      r_tmo <= '0;
    end
  end

  // Response status and read-data capture; an abort zeroes the read data.
  always_ff @(posedge wbm_clk_i) begin
    if (!wbm_rst_ni) begin
      r_status <= ST_OK;
      r_rdata  <= 32'h0;
    end else begin
      if ((r_state == S_CMD) && rx_valid_i && w_bad_cmd) begin
        r_status <= ST_BAD;
      end else if (w_done) begin
        r_status <= ST_OK;
        if (!r_we) begin
          r_rdata <= wbm_dat_i;
        end
      end else if (w_abort) begin
        r_status <= ST_TMO;
        r_rdata  <= 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_wbm_spi_ctrl.sv
// Bench for wbm_spi_ctrl: drives command frames over rx, models a Wishbone slave,
// and scoreboards the expected Wishbone requests and tx response bytes.
module tb_wbm_spi_ctrl;

  localparam int TMO = 8;

  logic        wbm_clk_i;
  logic        wbm_rst_ni;
  logic        rx_valid_i;
  logic [7:0]  rx_data_i;
  logic        rx_ack_o;
  logic        tx_valid_o;
  logic [7:0]  tx_data_o;
  logic        tx_ack_i;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [7:0]  wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_stall_i;
  logic        wbm_ack_i;

  wbm_spi_ctrl #(.TIMEOUT(TMO)) dut (
    .wbm_clk_i   (wbm_clk_i),
    .wbm_rst_ni  (wbm_rst_ni),
    .rx_valid_i  (rx_valid_i),
    .rx_data_i   (rx_data_i),
    .rx_ack_o    (rx_ack_o),
    .tx_valid_o  (tx_valid_o),
    .tx_data_o   (tx_data_o),
    .tx_ack_i    (tx_ack_i),
    .wbm_cyc_o   (wbm_cyc_o),
    .wbm_stb_o   (wbm_stb_o),
    .wbm_we_o    (wbm_we_o),
    .wbm_sel_o   (wbm_sel_o),
    .wbm_adr_o   (wbm_adr_o),
    .wbm_dat_o   (wbm_dat_o),
    .wbm_dat_i   (wbm_dat_i),
    .wbm_stall_i (wbm_stall_i),
    .wbm_ack_i   (wbm_ack_i)
  );

  initial wbm_clk_i = 1'b0;
  always #5 wbm_clk_i = ~wbm_clk_i;

  typedef struct {
    logic        we;
    logic [3:0]  sel;
    logic [7:0]  adr;
    logic [31:0] dat;
  } req_t;

  logic [7:0] exp_tx[$];
  req_t       exp_req[$];

  int errors = 0;
  int checks = 0;

  // Slave model knobs, set by the test sequence before each frame.
  int          stall_left  = 0;
  int          ack_delay   = 1;
  int          ack_cnt     = 0;
  bit          never_ack   = 1'b0;
  bit          accepted    = 1'b0;
  logic [31:0] slave_rdata = 32'h0;
  int          stb_cycles  = 0;
  int          cyc_cycles  = 0;
  int          tx_budget   = 1000;
  int          tx_n        = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Wishbone slave: stalls, accepts, checks the request, acks after a delay.
  initial begin
    req_t r;
    wbm_stall_i = 1'b0;
    wbm_ack_i   = 1'b0;
    wbm_dat_i   = 32'h0;
    forever begin
      @(negedge wbm_clk_i);
      wbm_ack_i   = 1'b0;
      wbm_stall_i = 1'b0;
      wbm_dat_i   = ~slave_rdata;
      if (!wbm_cyc_o) begin
        accepted = 1'b0;
      end else begin
        cyc_cycles++;
        if (wbm_stb_o) begin
          stb_cycles++;
          if (stall_left > 0) begin
            wbm_stall_i = 1'b1;
            stall_left--;
          end else begin
            accepted = 1'b1;
            if (exp_req.size() == 0) begin
              chk("req_extra", {24'h0, wbm_adr_o}, 32'h100);
            end else begin
              r = exp_req.pop_front();
              chk("req_we", 32'(wbm_we_o), 32'(r.we));
              chk("req_sel", 32'(wbm_sel_o), 32'(r.sel));
              chk("req_adr", 32'(wbm_adr_o), 32'(r.adr));
              if (r.we) chk("req_dat", wbm_dat_o, r.dat);
            end
            ack_cnt = ack_delay;
            if (ack_cnt == 0 && !never_ack) begin
              wbm_ack_i = 1'b1;
              wbm_dat_i = slave_rdata;
            end
          end
        end else if (accepted && !never_ack) begin
          ack_cnt--;
          if (ack_cnt == 0) begin
            wbm_ack_i = 1'b1;
            wbm_dat_i = slave_rdata;
          end
        end
      end
    end
  end

  // tx sink: takes bytes while budget remains and compares them to the scoreboard.
  initial begin
    logic [7:0] e;
    tx_ack_i = 1'b0;
    forever begin
      @(negedge wbm_clk_i);
      if (tx_valid_o && tx_budget > 0) begin
        tx_ack_i = 1'b1;
        tx_budget--;
        if (exp_tx.size() == 0) begin
          chk("tx_extra", {24'h0, tx_data_o}, 32'h100);
        end else begin
          e = exp_tx.pop_front();
          chk($sformatf("tx%0d", tx_n), 32'(tx_data_o), 32'(e));
        end
        tx_n++;
      end else begin
        tx_ack_i = 1'b0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge wbm_clk_i);
    rx_valid_i = 1'b1;
    rx_data_i  = b;
    #1;
    while (!rx_ack_o && n < 200) begin
      @(negedge wbm_clk_i);
      #1;
      n++;
    end
    chk("rx_accept", 32'(rx_ack_o), 32'd1);
    @(posedge wbm_clk_i);
  endtask

  task automatic end_frame(input bit expect_stb);
    @(negedge wbm_clk_i);
    rx_valid_i = 1'b0;
    chk("stb_latency", 32'(wbm_stb_o), 32'(expect_stb));
  endtask

  task automatic do_write(input logic [3:0] sel, input logic [7:0] adr, input logic [31:0] dat);
    req_t r;
    r.we = 1'b1; r.sel = sel; r.adr = adr; r.dat = dat;
    exp_req.push_back(r);
    send_byte({4'h8, sel});
    send_byte(adr);
    for (int i = 3; i >= 0; i--) send_byte(dat[8*i +: 8]);
    end_frame(1'b1);
  endtask

  task automatic do_read(input logic [3:0] sel, input logic [7:0] adr);
    req_t r;
    r.we = 1'b0; r.sel = sel; r.adr = adr; r.dat = 32'h0;
    exp_req.push_back(r);
    send_byte({4'h0, sel});
    send_byte(adr);
    end_frame(1'b1);
  endtask

  task automatic push_rd(input logic [7:0] st, input logic [31:0] d);
    exp_tx.push_back(st);
    for (int i = 3; i >= 0; i--) exp_tx.push_back(d[8*i +: 8]);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_tx.size() != 0 && n < 500) begin
      @(negedge wbm_clk_i);
      n++;
    end
    chk({tag, "_drain"}, 32'(exp_tx.size()), 32'd0);
    repeat (3) @(negedge wbm_clk_i);
  endtask

  task automatic clr_counts;
    stb_cycles = 0;
    cyc_cycles = 0;
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge wbm_clk_i);
    wbm_rst_ni = 1'b0;
    @(negedge wbm_clk_i);
    chk({tag, "_cyc"}, 32'(wbm_cyc_o), 32'd0);
    chk({tag, "_stb"}, 32'(wbm_stb_o), 32'd0);
    chk({tag, "_txv"}, 32'(tx_valid_o), 32'd0);
    wbm_rst_ni = 1'b1;
  endtask

  initial begin
    int n;
    wbm_rst_ni = 1'b0;
    rx_valid_i = 1'b0;
    rx_data_i  = 8'h00;

    // Reset state
    repeat (3) @(negedge wbm_clk_i);
    chk("rst_cyc", 32'(wbm_cyc_o), 32'd0);
    chk("rst_stb", 32'(wbm_stb_o), 32'd0);
    chk("rst_we", 32'(wbm_we_o), 32'd0);
    chk("rst_sel", 32'(wbm_sel_o), 32'd0);
    chk("rst_adr", 32'(wbm_adr_o), 32'd0);
    chk("rst_dat", wbm_dat_o, 32'd0);
    chk("rst_txv", 32'(tx_valid_o), 32'd0);
    chk("rst_txd", 32'(tx_data_o), 32'd0);
    chk("rst_rxack", 32'(rx_ack_o), 32'd0);
    wbm_rst_ni = 1'b1;
    repeat (2) @(negedge wbm_clk_i);

    // Write, ack one cycle after stb, no stall
    clr_counts(); ack_delay = 1; stall_left = 0;
    exp_tx.push_back(8'h00);
    do_write(4'hF, 8'h10, 32'hDEADBEEF);
    drain("wr");
    chk("wr_stb_cycles", 32'(stb_cycles), 32'd1);
    chk("wr_cyc_cycles", 32'(cyc_cycles), 32'd2);

    // Read with three stall cycles, ack two cycles after acceptance
    clr_counts(); ack_delay = 2; stall_left = 3; slave_rdata = 32'h12345678;
    push_rd(8'h00, 32'h12345678);
    do_read(4'h3, 8'h24);
    drain("rd");
    chk("rd_stb_cycles", 32'(stb_cycles), 32'd4);
    chk("rd_cyc_cycles", 32'(cyc_cycles), 32'd6);

    // Same-cycle ack on the first stb cycle
    clr_counts(); ack_delay = 0; stall_left = 0;
    exp_tx.push_back(8'h00);
    do_write(4'h1, 8'h33, 32'h01020304);
    @(negedge wbm_clk_i);
    chk("sc_cyc_next", 32'(wbm_cyc_o), 32'd0);
    chk("sc_stb_next", 32'(wbm_stb_o), 32'd0);
    chk("sc_txv_next", 32'(tx_valid_o), 32'd1);
    drain("sc");
    chk("sc_cyc_cycles", 32'(cyc_cycles), 32'd1);

    // Timeout on a read the slave never acks
    clr_counts(); never_ack = 1'b1; ack_delay = 1; slave_rdata = 32'h55AA55AA;
    push_rd(8'hEE, 32'h0);
    do_read(4'hF, 8'h40);
    drain("tmo");
    chk("tmo_cyc_cycles", 32'(cyc_cycles), 32'(TMO));
    chk("tmo_stb_cycles", 32'(stb_cycles), 32'd1);
    never_ack = 1'b0;

    // Bad command, then the next byte starts a fresh read
    clr_counts(); ack_delay = 1; slave_rdata = 32'hCAFEF00D;
    exp_tx.push_back(8'hC0);
    send_byte(8'h40);
    end_frame(1'b0);
    drain("bad");
    chk("bad_cyc_cycles", 32'(cyc_cycles), 32'd0);
    push_rd(8'h00, 32'hCAFEF00D);
    do_read(4'h1, 8'h55);
    drain("after_bad");

    // Reset while waiting for ack
    never_ack = 1'b1;
    do_read(4'hF, 8'h60);
    n = 0;
    while (!(wbm_cyc_o && !wbm_stb_o) && n < 50) begin
      @(negedge wbm_clk_i);
      n++;
    end
    chk("rw_in_wait", 32'(wbm_cyc_o && !wbm_stb_o), 32'd1);
    pulse_reset("rst_wait");
    never_ack = 1'b0;

    // Reset during read-data with tx_ack held low after two bytes
    ack_delay = 1; slave_rdata = 32'h11223344; tx_budget = 2;
    exp_tx.push_back(8'h00);
    exp_tx.push_back(8'h11);
    do_read(4'hF, 8'h70);
    drain("rdat");
    chk("rdat_txv", 32'(tx_valid_o), 32'd1);
    chk("rdat_hold", 32'(tx_data_o), 32'h22);
    pulse_reset("rst_rdata");
    tx_budget = 1000;

    // Write after reset completes normally
    clr_counts(); ack_delay = 1;
    exp_tx.push_back(8'h00);
    do_write(4'h5, 8'h7E, 32'hCAFEBABE);
    drain("post_rst");
    chk("post_cyc_cycles", 32'(cyc_cycles), 32'd2);
    chk("req_left", 32'(exp_req.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
